// File: rtl/axis_checker_chip.sv
// AXI4-Stream pass-through with a 2-entry skid buffer and an upstream protocol checker.
// Counts accepted beats/packets and raises sticky flags on unstable or dropped stalled beats.
module axis_checker_chip #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  err_stable,
    output logic                  err_drop,
    input  logic                  clr
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic                  out_valid_reg, out_valid_next;
    logic [DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                  out_last_reg, out_last_next;
    logic                  skid_valid_reg, skid_valid_next;
    logic [DATA_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic                  skid_last_reg, skid_last_next;
    logic                  ready_reg, ready_next;

    logic                  prev_valid_reg;
    logic                  prev_ready_reg;
    logic [DATA_WIDTH-1:0] prev_data_reg;
    logic                  prev_last_reg;

    logic                  err_stable_reg, err_stable_next;
    logic                  err_drop_reg, err_drop_next;
    logic [CNT_WIDTH-1:0]  beat_count_reg, beat_count_next;
    logic [CNT_WIDTH-1:0]  pkt_count_reg, pkt_count_next;

    logic                  s_hs;
    logic                  out_drain;
    logic                  prev_stalled;
    logic [NUM_BYTES-1:0]  byte_diff;
    logic                  payload_changed;

    assign s_hs      = s_axis_tvalid & ready_reg;
    assign out_drain = ~out_valid_reg | m_axis_tready;

    // Skid buffer: OUT is refilled from SKID first so ordering stays FIFO.
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_last_next   = out_last_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_last_next  = skid_last_reg;
        if (out_drain) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_data_next   = skid_data_reg;
                out_last_next   = skid_last_reg;
                skid_valid_next = 1'b0;
            end else if (s_hs) begin
                out_valid_next = 1'b1;
                out_data_next  = s_axis_tdata;
                out_last_next  = s_axis_tlast;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (s_hs) begin
            skid_valid_next = 1'b1;
            skid_data_next  = s_axis_tdata;
            skid_last_next  = s_axis_tlast;
        end
        ready_next = ~skid_valid_next;
    end

    // Byte-lane compare of the held payload against the previous cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            assign byte_diff[gi] = prev_data_reg[gi*8 +: 8] != s_axis_tdata[gi*8 +: 8];
        end
    endgenerate

    assign prev_stalled    = prev_valid_reg & ~prev_ready_reg;
    assign payload_changed = (|byte_diff) | (prev_last_reg != s_axis_tlast);

    always_comb begin
        err_stable_next = err_stable_reg;
        err_drop_next   = err_drop_reg;
        beat_count_next = beat_count_reg;
        pkt_count_next  = pkt_count_reg;
        if (clr) begin
            err_stable_next = 1'b0;
            err_drop_next   = 1'b0;
            beat_count_next = '0;
            pkt_count_next  = '0;
        end else begin
            if (prev_stalled && !s_axis_tvalid)
                err_drop_next = 1'b1;
            if (prev_stalled && s_axis_tvalid && payload_changed)
                err_stable_next = 1'b1;
            if (s_hs) begin
                beat_count_next = beat_count_reg + CNT_WIDTH'(1);
                if (s_axis_tlast)
                    pkt_count_next = pkt_count_reg + CNT_WIDTH'(1);
            end
        end
    end

    // aresetn is active-high despite its name.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_last_reg  <= 1'b0;
            ready_reg      <= 1'b0;
            prev_valid_reg <= 1'b0;
            prev_ready_reg <= 1'b0;
            prev_data_reg  <= '0;
            prev_last_reg  <= 1'b0;
            err_stable_reg <= 1'b0;
            err_drop_reg   <= 1'b0;
            beat_count_reg <= '0;
            pkt_count_reg  <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_last_reg   <= out_last_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_last_reg  <= skid_last_next;
            ready_reg      <= ready_next;
            prev_valid_reg <= s_axis_tvalid;
            prev_ready_reg <= ready_reg;
            prev_data_reg  <= s_axis_tdata;
            prev_last_reg  <= s_axis_tlast;
            err_stable_reg <= err_stable_next;
            err_drop_reg   <= err_drop_next;
            beat_count_reg <= beat_count_next;
            pkt_count_reg  <= pkt_count_next;
        end
    end

    assign s_axis_tready = ready_reg;
    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tdata  = out_data_reg;
    assign m_axis_tlast  = out_last_reg;
    assign beat_count    = beat_count_reg;
    assign pkt_count     = pkt_count_reg;
    assign err_stable    = err_stable_reg;
    assign err_drop      = err_drop_reg;

endmodule

// File: tb/tb_axis_checker_chip.sv
// Directed bench for axis_checker_chip: streaming, backpressure, violations, clr and mid-packet reset.
module tb_axis_checker_chip;

    logic        aclk;
    logic        aresetn;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] beat_count;
    logic [31:0] pkt_count;
    logic        err_stable;
    logic        err_drop;
    logic        clr;

    int checks;
    int failures;

    logic [63:0] cap_d [64];
    logic        cap_l [64];
    int          cap_n;

    axis_checker_chip #(.DATA_WIDTH(64), .CNT_WIDTH(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .beat_count    (beat_count),
        .pkt_count     (pkt_count),
        .err_stable    (err_stable),
        .err_drop      (err_drop),
        .clr           (clr)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Record every downstream beat that will transfer on the coming rising edge.
    initial cap_n = 0;
    always @(negedge aclk) begin
        if (!aresetn && m_axis_tvalid && m_axis_tready && cap_n < 64) begin
            cap_d[cap_n] = m_axis_tdata;
            cap_l[cap_n] = m_axis_tlast;
            $display("out beat %0d data=%h last=%0b", cap_n, m_axis_tdata, m_axis_tlast);
            cap_n = cap_n + 1;
        end
    end

    function automatic logic [63:0] beat_data(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {b, 56'h0};
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int n, input int total);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat_data(n);
        s_axis_tlast  = (n == total - 1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    // Send 8 beats back to back with m_axis_tready high, checking 1-cycle latency.
    task automatic send8(input string tag);
        m_axis_tready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            set_beat(n, 8);
            chk({tag, "_s_ready"}, 64'(s_axis_tready), 64'(1));
            step();
            chk({tag, "_m_valid"}, 64'(m_axis_tvalid), 64'(1));
            chk({tag, "_m_data"}, m_axis_tdata, beat_data(n));
            chk({tag, "_m_last"}, 64'(m_axis_tlast), 64'(n == 7));
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        step();
        step();
    endtask

    task automatic chk_stream(input string tag, input int base, input int total);
        chk({tag, "_count"}, 64'(cap_n - base), 64'(total));
        for (int i = 0; i < total; i++) begin
            if (base + i < cap_n) begin
                chk({tag, "_data"}, cap_d[base + i], beat_data(i));
                chk({tag, "_last"}, 64'(cap_l[base + i]), 64'(i == total - 1));
            end
        end
    endtask

    task automatic chk_stats(input string tag, input int beats, input int pkts);
        chk({tag, "_beats"}, 64'(beat_count), 64'(beats));
        chk({tag, "_pkts"}, 64'(pkt_count), 64'(pkts));
        chk({tag, "_err_stable"}, 64'(err_stable), 64'(0));
        chk({tag, "_err_drop"}, 64'(err_drop), 64'(0));
    endtask

    initial begin
        int base;
        int idx;
        int occ;
        logic sh;
        logic mh;

        checks        = 0;
        failures      = 0;
        aresetn       = 1'b1;
        clr           = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hdead_beef_cafe_f00d;
        s_axis_tlast  = 1'b1;
        m_axis_tready = 1'b1;

        // 1: reset held, then released
        step();
        step();
        step();
        chk("rst_s_ready", 64'(s_axis_tready), 64'(0));
        chk("rst_m_valid", 64'(m_axis_tvalid), 64'(0));
        chk("rst_m_data", m_axis_tdata, 64'(0));
        chk("rst_m_last", 64'(m_axis_tlast), 64'(0));
        chk_stats("rst", 0, 0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 64'h0;
        aresetn       = 1'b0;
        step();
        chk("rel_s_ready", 64'(s_axis_tready), 64'(1));
        chk("rel_m_valid", 64'(m_axis_tvalid), 64'(0));

        // 2: full-rate 8-beat packet
        base = cap_n;
        send8("t2");
        chk_stream("t2_stream", base, 8);
        chk_stats("t2", 8, 1);
        chk("t2_beat3", cap_d[base + 3], 64'h0300_0000_0000_0000);
        pulse_clr();

        // 3: downstream ready 2 low / 6 high; buffer is full exactly when 2 beats are held
        base = cap_n;
        idx  = 0;
        occ  = 0;
        set_beat(0, 8);
        for (int c = 0; c < 80 && !(idx == 8 && occ == 0); c++) begin
            m_axis_tready = ((c % 8) >= 2);
            sh = s_axis_tvalid & s_axis_tready;
            mh = m_axis_tvalid & m_axis_tready;
            step();
            occ = occ + int'(sh) - int'(mh);
            if (sh) begin
                idx++;
                if (idx < 8) set_beat(idx, 8);
                else begin
                    s_axis_tvalid = 1'b0;
                    s_axis_tlast  = 1'b0;
                end
            end
            chk("t3_s_ready", 64'(s_axis_tready), 64'(occ < 2));
        end
        chk("t3_done", 64'(idx == 8 && occ == 0), 64'(1));
        chk_stream("t3_stream", base, 8);
        chk_stats("t3", 8, 1);
        pulse_clr();

        // 4: stalled output, 3 beats presented
        base = cap_n;
        m_axis_tready = 1'b0;
        set_beat(0, 3);
        chk("t4_ready0", 64'(s_axis_tready), 64'(1));
        step();
        set_beat(1, 3);
        chk("t4_ready1", 64'(s_axis_tready), 64'(1));
        step();
        set_beat(2, 3);
        chk("t4_ready_low", 64'(s_axis_tready), 64'(0));
        chk("t4_hold_data", m_axis_tdata, beat_data(0));
        step();
        step();
        chk("t4_still_low", 64'(s_axis_tready), 64'(0));
        chk("t4_beats2", 64'(beat_count), 64'(2));
        chk("t4_hold_data2", m_axis_tdata, beat_data(0));
        m_axis_tready = 1'b1;
        step();
        chk("t4_ready_rise", 64'(s_axis_tready), 64'(1));
        chk("t4_out_b1", m_axis_tdata, beat_data(1));
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("t4_out_b2", m_axis_tdata, beat_data(2));
        step();
        chk("t4_drained", 64'(m_axis_tvalid), 64'(0));
        chk_stream("t4_stream", base, 3);
        chk_stats("t4", 3, 1);
        pulse_clr();

        // 5: protocol violations
        m_axis_tready = 1'b0;
        set_beat(10, 16);
        step();
        set_beat(11, 16);
        step();
        set_beat(12, 16);
        step();
        chk("t5_no_err_yet", 64'(err_stable), 64'(0));
        set_beat(13, 16);
        step();
        chk("t5_err_stable", 64'(err_stable), 64'(1));
        chk("t5_no_drop", 64'(err_drop), 64'(0));
        step();
        chk("t5_stable_sticky", 64'(err_stable), 64'(1));
        pulse_clr();
        chk_stats("t5_clr1", 0, 0);
        s_axis_tvalid = 1'b0;
        step();
        chk("t5_err_drop", 64'(err_drop), 64'(1));
        chk("t5_drop_only", 64'(err_stable), 64'(0));
        step();
        chk("t5_drop_sticky", 64'(err_drop), 64'(1));
        pulse_clr();
        chk_stats("t5_clr2", 0, 0);
        m_axis_tready = 1'b1;
        step();
        step();
        step();
        chk("t5_drained", 64'(m_axis_tvalid), 64'(0));

        // 6: clr beats a same-cycle handshake; then reset after beat 4 of 8
        m_axis_tready = 1'b1;
        clr = 1'b1;
        set_beat(0, 8);
        step();
        clr = 1'b0;
        chk("t6_clr_wins", 64'(beat_count), 64'(0));
        chk("t6_clr_keeps_data", m_axis_tdata, beat_data(0));
        for (int n = 1; n < 4; n++) begin
            set_beat(n, 8);
            step();
        end
        chk("t6_beats3", 64'(beat_count), 64'(3));
        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        step();
        chk("t6_rst_s_ready", 64'(s_axis_tready), 64'(0));
        chk("t6_rst_m_valid", 64'(m_axis_tvalid), 64'(0));
        chk("t6_rst_m_data", m_axis_tdata, 64'(0));
        chk_stats("t6_rst", 0, 0);
        aresetn = 1'b0;
        step();
        chk("t6_rel_s_ready", 64'(s_axis_tready), 64'(1));
        base = cap_n;
        send8("t6");
        chk_stream("t6_stream", base, 8);
        chk_stats("t6", 8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
